id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage RV32I core.
- Sits between IF/ID and EX. Drives the regfile read addresses and consumes its rd1/rd2 data.
- Adds a WB-to-ID bypass, because the regfile writes on the rising edge and would otherwise return stale data.
- Detects load-use hazards, generates the upstream stall, and inserts bubbles on stall or on a branch/jump flush.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSTR, 32'h0000_0013, encoding presented on instr_e for a bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_d  in  32  instruction from IF/ID.
- pc_d  in  XLEN  PC of instr_d.
- valid_d  in  1  instr_d holds a real instruction.
- flush_e  in  1  EX resolved a taken branch/jump; kill the ID instruction.
- a1, a2  out  5  regfile read addresses; combinational from instr_d[19:15] and [24:20].
- rd1, rd2  in  XLEN  regfile read data (x0 already reads 0).
- wb_we  in  1  WB write enable (same signal as the regfile write port).
- wb_rd  in  5  WB destination register.
- wb_wd  in  XLEN  WB write data.
- stall_d  out  1  hold PC and IF/ID this cycle; combinational.
- valid_e  out  1  ID/EX holds a real instruction.
- instr_e  out  32  registered instruction.
- pc_e  out  XLEN  registered PC.
- rs1_val_e, rs2_val_e  out  XLEN  registered operands after bypass.
- rs1_e, rs2_e, rd_e  out  5  registered register indices, used by EX forwarding.
- imm_e  out  XLEN  registered sign-extended immediate.
- ctrl_e  out  ctrl_t  registered control bundle: reg_write, mem_read, mem_write, alu_src, result_src[1:0], branch, jump, alu_ctrl[3:0].
- stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): valid_e=0, instr_e=NOP_INSTR, pc_e=0, all operands/indices/imm=0, ctrl_e all 0 (no write, no memory op).
- Decode is combinational from instr_d. Opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Any other opcode decodes to an all-zero ctrl (no side effects) with valid still propagated.
- Immediate: I/S/B/U/J formats, sign-extended to XLEN. B and J immediates have bit0=0. U immediate is instr[31:12]<<12.
- Bypass: if wb_we && wb_rd!=0 && wb_rd==rs1, rs1 value = wb_wd, else rd1. The rs2 path is identical.
- Load-use hazard: hz = valid_d && valid_e && ctrl_e.mem_read && rd_e!=0 && (rd_e==rs1 || rd_e==rs2).
  - Both source fields are compared regardless of format; a false stall is permitted.
  - stall_d = hz && !flush_e.
- Next-state priority: reset > flush_e > hz > normal.
  - flush_e: load a bubble, i.e. the reset values with instr_e=NOP_INSTR and valid_e=0.
  - hz: load a bubble. The ID instruction is retried the next cycle, with stall_d holding IF/ID.
  - normal: capture the decoded fields. valid_e=valid_d. When valid_d=0, ctrl_e is forced to zero.
- Latency: an instruction is in ID/EX one cycle after it is in ID. A load-use pair costs exactly one bubble.
- flush_e and hz in the same cycle: bubble, and stall_d=0 (the ID instruction is dead).
- Reset mid-stall: stall_d drops with valid_e=0 and no hazard is held across reset.

Optional Feature:
- Macro: ID_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with stall_d=1.
  - flush_cnt increments on each cycle with flush_e=1 && valid_d.
  - Both are 32-bit, wrap 0xFFFF_FFFF->0, and reset to 0.
- Undefined: no counter flops are built; both outputs are tied to 0.

Decomposition:
- Package riscv_pkg:
  - opcode localparams (OP_R=7'b0110011, OP_LOAD=7'b0000011, etc.).
  - alu_ctrl_e enum.
  - result_src encodings (ALU, MEM, PC+4).
  - ctrl_t packed struct.
  - NOP constant.
- One sub-module, imm_gen: combinational instr -> imm, reusable by the branch unit.
- Decode and the hazard logic stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> valid_e=0, instr_e=32'h13, ctrl_e=0, stall_d=0. Deassert -> first valid instr appears on the next edge.
- WB bypass: wb_we=1, wb_rd=5, wb_wd=32'hDEAD_BEEF, rd1=0, instr_d=add x6,x5,x0 -> rs1_val_e=32'hDEAD_BEEF. Same test with wb_rd=0 -> rs1_val_e=rd1.
- Load-use: lw x7,0(x1) then add x8,x7,x2 -> stall_d=1 for exactly one cycle, one bubble in ID/EX, add captured on the following edge. With rd=x0 -> no stall.
- Flush: flush_e=1 with a valid add in ID -> next valid_e=0, ctrl_e.reg_write=0. Flush coincident with a hazard -> stall_d=0, bubble.
- Immediates: beq with offset -4 -> imm_e=32'hFFFF_FFFC. lui x1,0x12345 -> imm_e=32'h1234_5000. sw offset -1 -> 32'hFFFF_FFFF.
- ID_PERF_CNT_EN: 3 hazard stalls and 2 flushes -> stall_cnt=3, flush_cnt=2. Force stall_cnt=0xFFFF_FFFF, then one stall -> 0. With the macro undefined -> both read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, ALU/result encodings, control bundle and bubble encoding
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } alu_ctrl_e;
  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    logic [1:0] result_src;
    logic      branch;
    logic      jump;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;
  // funct7[5] selects SUB only for register-register ops; shifts use it for SRA in both forms
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction (I/S/B/U/J), sign-extended to XLEN
//   i_instr : instruction word
//   o_imm   : immediate, zero for formats without one
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);
  logic [31:0] w_imm;
  always_comb begin
    w_imm = '0;
    case (i_instr[6:0])
      OP_I, OP_LOAD, OP_JALR: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE:               w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BRANCH:              w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       w_imm = {i_instr[31:12], 12'b0};
      OP_JAL:                 w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: ;
    endcase
  end
  assign o_imm = XLEN'($signed(w_imm));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode + ID/EX register with WB bypass, load-use stall and flush bubbles
//   in : clk, rst_n (async active-low), instr_d/pc_d/valid_d from IF/ID, flush_e from EX,
//        rd1/rd2 regfile data, wb_we/wb_rd/wb_wd writeback port
//   out: a1/a2 regfile addresses, stall_d, registered *_e fields, stall_cnt/flush_cnt
//   Optional macro ID_PERF_CNT_EN builds the stall/flush counters; otherwise they read 0.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            valid_d,
  input  logic            flush_e,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  output logic            stall_d,
  output logic            valid_e,
  output logic [31:0]     instr_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] rs1_val_e,
  output logic [XLEN-1:0] rs2_val_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] imm_e,
  output ctrl_t           ctrl_e,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;
  ctrl_t           w_ctrl;
  logic            w_hz, w_load;
  logic            r_valid_e;
  logic [31:0]     r_instr_e;
  logic [XLEN-1:0] r_pc_e, r_rs1_val_e, r_rs2_val_e, r_imm_e;
  logic [4:0]      r_rs1_e, r_rs2_e, r_rd_e;
  ctrl_t           r_ctrl_e;
  assign w_rs1 = instr_d[19:15];
  assign w_rs2 = instr_d[24:20];
  assign w_rd  = instr_d[11:7];
  assign a1 = w_rs1;
  assign a2 = w_rs2;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (.i_instr(instr_d), .o_imm(w_imm));
  always_comb begin
    w_ctrl = '0;
    case (instr_d[6:0])
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_ctrl  = alu_op(instr_d[14:12], instr_d[30], 1'b1);
      end
      OP_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = alu_op(instr_d[14:12], instr_d[30], 1'b0);
      end
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.branch   = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end
  // regfile writes on the same edge we capture, so a WB write to a source must bypass it
  assign w_rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs1) ? wb_wd : rd1;
  assign w_rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs2) ? wb_wd : rd2;
  // both fields compared irrespective of format; a spurious stall only costs a cycle
  assign w_hz = valid_d && r_valid_e && r_ctrl_e.mem_read && r_rd_e != 5'd0 &&
                (r_rd_e == w_rs1 || r_rd_e == w_rs2);
  assign stall_d = w_hz && !flush_e;
  assign w_load  = !(flush_e || w_hz);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_e   <= 1'b0;
      r_instr_e   <= NOP_INSTR;
      r_pc_e      <= '0;
      r_rs1_val_e <= '0;
      r_rs2_val_e <= '0;
      r_rs1_e     <= '0;
      r_rs2_e     <= '0;
      r_rd_e      <= '0;
      r_imm_e     <= '0;
      r_ctrl_e    <= '0;
    end else begin
      r_valid_e   <= w_load && valid_d;
      r_instr_e   <= w_load ? instr_d : NOP_INSTR;
      r_pc_e      <= w_load ? pc_d : '0;
      r_rs1_val_e <= w_load ? w_rs1_val : '0;
      r_rs2_val_e <= w_load ? w_rs2_val : '0;
      r_rs1_e     <= w_load ? w_rs1 : '0;
      r_rs2_e     <= w_load ? w_rs2 : '0;
      r_rd_e      <= w_load ? w_rd : '0;
      r_imm_e     <= w_load ? w_imm : '0;
      r_ctrl_e    <= (w_load && valid_d) ? w_ctrl : ctrl_t'('0);
    end
  end
  assign valid_e   = r_valid_e;
  assign instr_e   = r_instr_e;
  assign pc_e      = r_pc_e;
  assign rs1_val_e = r_rs1_val_e;
  assign rs2_val_e = r_rs2_val_e;
  assign rs1_e     = r_rs1_e;
  assign rs2_e     = r_rs2_e;
  assign rd_e      = r_rd_e;
  assign imm_e     = r_imm_e;
  assign ctrl_e    = r_ctrl_e;
`ifdef ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(stall_d);
      r_flush_cnt <= r_flush_cnt + 32'(flush_e && valid_d);
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import riscv_pkg::*;
  localparam logic [31:0] ADD_6_5_0 = 32'h0002_8333;
  localparam logic [31:0] ADD_8_7_2 = 32'h0023_8433;
  localparam logic [31:0] LW_7      = 32'h0000_A383;
  localparam logic [31:0] LW_0      = 32'h0000_A003;
  localparam logic [31:0] BEQ_M4    = 32'hFE00_0EE3;
  localparam logic [31:0] LUI_1     = 32'h1234_50B7;
  localparam logic [31:0] SW_M1     = 32'hFE00_2FA3;
  localparam ctrl_t C_ADD = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0,
                              result_src:RES_ALU, branch:1'b0, jump:1'b0, alu_ctrl:ALU_ADD};
  localparam ctrl_t C_LW  = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, alu_src:1'b1,
                              result_src:RES_MEM, branch:1'b0, jump:1'b0, alu_ctrl:ALU_ADD};
  localparam ctrl_t C_SW  = '{reg_write:1'b0, mem_read:1'b0, mem_write:1'b1, alu_src:1'b1,
                              result_src:RES_ALU, branch:1'b0, jump:1'b0, alu_ctrl:ALU_ADD};
  localparam ctrl_t C_BEQ = '{reg_write:1'b0, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0,
                              result_src:RES_ALU, branch:1'b1, jump:1'b0, alu_ctrl:ALU_SUB};
  localparam ctrl_t C_LUI = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b1,
                              result_src:RES_ALU, branch:1'b0, jump:1'b0, alu_ctrl:ALU_LUI};
  logic        clk = 1'b0, rst_n;
  logic [31:0] instr_d, pc_d, rd1, rd2, wb_wd;
  logic        valid_d, flush_e, wb_we;
  logic [4:0]  wb_rd, a1, a2, rs1_e, rs2_e, rd_e;
  logic        stall_d, valid_e;
  logic [31:0] instr_e, pc_e, rs1_val_e, rs2_val_e, imm_e, stall_cnt, flush_cnt;
  ctrl_t       ctrl_e;
  int checks = 0, errors = 0;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .flush_e(flush_e), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .stall_d(stall_d), .valid_e(valid_e),
    .instr_e(instr_e), .pc_e(pc_e), .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; valid_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_d = $urandom; pc_d = $urandom; flush_e = 1'($urandom_range(0, 1));
      rd1 = $urandom; rd2 = $urandom; wb_we = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom); wb_wd = $urandom;
      tick;
    end
    chk("rst valid_e", 32'(valid_e), 32'd0);
    chk("rst instr_e", instr_e, 32'h13);
    chk("rst ctrl_e", 32'(ctrl_e), 32'd0);
    chk("rst stall_d", 32'(stall_d), 32'd0);
    chk("rst pc_e", pc_e, 32'd0);
    chk("rst imm_e", imm_e, 32'd0);
    // release; first instruction lands on the next edge, rs1 bypassed from WB
    rst_n = 1'b1; flush_e = 1'b0; valid_d = 1'b1;
    instr_d = ADD_6_5_0; pc_d = 32'h100; rd1 = 32'd0; rd2 = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'hDEAD_BEEF;
    chk("a1", 32'(a1), 32'd5);
    chk("a2", 32'(a2), 32'd0);
    tick;
    chk("first valid_e", 32'(valid_e), 32'd1);
    chk("first instr_e", instr_e, ADD_6_5_0);
    chk("first pc_e", pc_e, 32'h100);
    chk("bypass rs1", rs1_val_e, 32'hDEAD_BEEF);
    chk("first rd_e", 32'(rd_e), 32'd6);
    chk("first rs1_e", 32'(rs1_e), 32'd5);
    chk("add ctrl", 32'(ctrl_e), 32'(C_ADD));
    wb_rd = 5'd0; rd1 = 32'h1111;
    tick;
    chk("wb x0 no bypass", rs1_val_e, 32'h1111);
    instr_d = ADD_8_7_2; wb_rd = 5'd2; wb_wd = 32'hCAFE; rd1 = 32'h7777; rd2 = 32'h2222;
    tick;
    chk("bypass rs2", rs2_val_e, 32'hCAFE);
    chk("rs1 from rd1", rs1_val_e, 32'h7777);
    chk("rs2_e", 32'(rs2_e), 32'd2);
    wb_we = 1'b0;
    tick;
    chk("wb_we=0 no bypass", rs2_val_e, 32'h2222);
    // load-use: one stall cycle, one bubble, dependent add follows
    instr_d = LW_7; pc_d = 32'h200;
    tick;
    chk("lw ctrl", 32'(ctrl_e), 32'(C_LW));
    chk("lw rd_e", 32'(rd_e), 32'd7);
    instr_d = ADD_8_7_2; pc_d = 32'h204;
    #1;
    chk("lu stall", 32'(stall_d), 32'd1);
    tick;
    chk("lu bubble valid", 32'(valid_e), 32'd0);
    chk("lu bubble instr", instr_e, 32'h13);
    chk("lu bubble ctrl", 32'(ctrl_e), 32'd0);
    chk("lu stall released", 32'(stall_d), 32'd0);
    tick;
    chk("lu add valid", 32'(valid_e), 32'd1);
    chk("lu add instr", instr_e, ADD_8_7_2);
    chk("lu add pc", pc_e, 32'h204);
    // load to x0 never stalls, even against an x0 source
    instr_d = LW_0;
    tick;
    instr_d = ADD_6_5_0;
    #1;
    chk("x0 load no stall", 32'(stall_d), 32'd0);
    tick;
    chk("x0 load no bubble", instr_e, ADD_6_5_0);
    // flush kills the ID instruction
    instr_d = ADD_8_7_2; flush_e = 1'b1;
    tick;
    flush_e = 1'b0;
    chk("flush valid_e", 32'(valid_e), 32'd0);
    chk("flush ctrl_e", 32'(ctrl_e), 32'd0);
    // flush coincident with hazard
    instr_d = LW_7;
    tick;
    instr_d = ADD_8_7_2; flush_e = 1'b1;
    #1;
    chk("flush+hz stall_d", 32'(stall_d), 32'd0);
    tick;
    flush_e = 1'b0;
    chk("flush+hz valid_e", 32'(valid_e), 32'd0);
    chk("flush+hz instr_e", instr_e, 32'h13);
    // flush with no valid instruction is not counted
    valid_d = 1'b0; flush_e = 1'b1;
    tick;
    flush_e = 1'b0; instr_d = ADD_6_5_0;
    tick;
    chk("invalid valid_e", 32'(valid_e), 32'd0);
    chk("invalid ctrl_e", 32'(ctrl_e), 32'd0);
    chk("invalid instr_e", instr_e, ADD_6_5_0);
    valid_d = 1'b1;
    instr_d = BEQ_M4;
    tick;
    chk("beq imm", imm_e, 32'hFFFF_FFFC);
    chk("beq ctrl", 32'(ctrl_e), 32'(C_BEQ));
    instr_d = LUI_1;
    tick;
    chk("lui imm", imm_e, 32'h1234_5000);
    chk("lui ctrl", 32'(ctrl_e), 32'(C_LUI));
    instr_d = SW_M1;
    tick;
    chk("sw imm", imm_e, 32'hFFFF_FFFF);
    chk("sw ctrl", 32'(ctrl_e), 32'(C_SW));
    for (int k = 0; k < 2; k++) begin
      instr_d = LW_7;
      tick;
      instr_d = ADD_8_7_2;
      #1;
      chk("lu stall again", 32'(stall_d), 32'd1);
      tick;
      tick;
    end
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
    force tb_id_ex_stage.dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release tb_id_ex_stage.dut.r_stall_cnt;
    instr_d = LW_7;
    tick;
    chk("stall_cnt preset", stall_cnt, 32'hFFFF_FFFF);
    instr_d = ADD_8_7_2;
    tick;
    chk("stall_cnt wrap", stall_cnt, 32'd0);
    tick;
`else
    chk("stall_cnt off", stall_cnt, 32'd0);
    chk("flush_cnt off", flush_cnt, 32'd0);
`endif
    // reset asserted in the middle of a stall
    instr_d = LW_7;
    tick;
    instr_d = ADD_8_7_2;
    #1;
    chk("pre-reset stall", 32'(stall_d), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-stall rst stall_d", 32'(stall_d), 32'd0);
    chk("mid-stall rst valid_e", 32'(valid_e), 32'd0);
    chk("mid-stall rst instr_e", instr_e, 32'h13);
    chk("mid-stall rst stall_cnt", stall_cnt, 32'd0);
    chk("mid-stall rst flush_cnt", flush_cnt, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post-reset valid_e", 32'(valid_e), 32'd1);
    chk("post-reset instr_e", instr_e, ADD_8_7_2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
